// File: rtl/i2s_pkg.sv
// Shared I2S constants: FSM state encoding, default word/slot widths, channel encoding.
package i2s_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RX_LEFT  = 2'd1;
  localparam logic [1:0] RX_RIGHT = 2'd2;

  localparam int DATA_BITS_DEFAULT = 24;
  localparam int SLOT_BITS_DEFAULT = 32;

  localparam logic LR_LEFT = 1'b0;

endpackage

// File: rtl/i2s_rx_sync.sv
// Two-flop synchroniser for bclk/lrclk/sdata with a bclk rising-edge strobe.
// Latency: 2 clk on every input, so the three synced signals stay aligned.
// Backpressure: none; free-running.
module i2s_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic bclk,
  input  logic lrclk,
  input  logic sdata,
  output logic rise,
  output logic lr_s,
  output logic sd_s
);

  logic [1:0] bclk_q;
  logic [1:0] lr_q;
  logic [1:0] sd_q;
  logic       bclk_prev;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bclk_q    <= 2'b00;
      lr_q      <= 2'b00;
      sd_q      <= 2'b00;
      bclk_prev <= 1'b0;
    end else begin
      bclk_q    <= {bclk_q[0], bclk};
      lr_q      <= {lr_q[0], lrclk};
      sd_q      <= {sd_q[0], sdata};
      bclk_prev <= bclk_q[1];
    end
  end

  assign rise = bclk_q[1] & ~bclk_prev;
  assign lr_s = lr_q[1];
  assign sd_s = sd_q[1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver, 24-bit stereo frames out on valid/ready; I2S_RX_OVERRUN_CNT_EN adds overrun_count.
// Latency: frame valid 1 clk after the rise cycle that completes the right word.
// Backpressure: one frame held; a frame completing while held and not accepted is dropped with an overrun pulse.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int SLOT_BITS = SLOT_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 bclk,
  input  logic                 lrclk,
  input  logic                 sdata,
  output logic [DATA_BITS-1:0] frame_l,
  output logic [DATA_BITS-1:0] frame_r,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 overrun,
`ifdef I2S_RX_OVERRUN_CNT_EN
  output logic [15:0]          overrun_count,
`endif
  output logic                 locked
);

  localparam logic [5:0] DB6 = 6'(DATA_BITS);

  if (SLOT_BITS < DATA_BITS + 1 || SLOT_BITS > 64) begin : g_bad_cfg
    $error("i2s_receiver: SLOT_BITS out of range");
  end

  logic                 rise;
  logic                 lr_s;
  logic                 sd_s;
  logic [1:0]           state;
  logic                 lr_prev;
  logic [5:0]           bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] left_hold;

  logic                 slot_start;
  logic [5:0]           cnt_inc;
  logic                 word_done;
  logic                 slot_full;
  logic                 frame_done;
  logic                 frame_drop;
  logic [DATA_BITS-1:0] word;

  i2s_rx_sync u_sync (
    .clk    (clk),
    .resetn (resetn),
    .bclk   (bclk),
    .lrclk  (lrclk),
    .sdata  (sdata),
    .rise   (rise),
    .lr_s   (lr_s),
    .sd_s   (sd_s)
  );

  always_comb begin
    slot_start = rise && (lr_s != lr_prev);
    cnt_inc    = (bitcnt == 6'd63) ? bitcnt : bitcnt + 6'd1;
    word       = {shreg[DATA_BITS-2:0], sd_s};
    // Completion keys off the pre-increment count so a saturated counter never re-completes.
    word_done  = rise && !slot_start && (bitcnt == DB6 - 6'd1);
    slot_full  = (bitcnt >= DB6);
    frame_done = word_done && (state == RX_RIGHT);
    frame_drop = frame_done && frame_valid && !frame_ready;
  end

  assign locked = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      lr_prev     <= 1'b0;
      bitcnt      <= 6'd0;
      shreg       <= '0;
      left_hold   <= '0;
      frame_l     <= '0;
      frame_r     <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;

      if (rise) begin
        lr_prev <= lr_s;
        if (slot_start) begin
          bitcnt <= 6'd0;
        end else begin
          bitcnt <= cnt_inc;
          if (bitcnt < DB6) shreg <= word;
        end
      end

      if (word_done && state == RX_LEFT) left_hold <= word;

      case (state)
        IDLE:     if (slot_start && lr_s == LR_LEFT) state <= RX_LEFT;
        RX_LEFT:  if (slot_start && lr_s != LR_LEFT) state <= slot_full ? RX_RIGHT : IDLE;
        RX_RIGHT: if (slot_start && lr_s == LR_LEFT) state <= slot_full ? RX_LEFT : IDLE;
        default:  state <= IDLE;
      endcase

      if (frame_done) begin
        if (!frame_valid || frame_ready) begin
          frame_l     <= left_hold;
          frame_r     <= word;
          frame_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_count <= 16'd0;
    end else if (frame_drop && overrun_count != 16'hFFFF) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: scoreboard of expected frames, checked on each valid/ready transfer.
module tb_i2s_receiver;

  localparam int DB = 24;

  logic          clk = 1'b0;
  logic          resetn;
  logic          bclk;
  logic          lrclk;
  logic          sdata;
  logic [DB-1:0] frame_l;
  logic [DB-1:0] frame_r;
  logic          frame_valid;
  logic          frame_ready;
  logic          overrun;
  logic          locked;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0]   overrun_count;
`endif

  int errors = 0;
  int checks = 0;
  int ovr_pulses = 0;
  logic [2*DB-1:0] sb[$];

  always #5 clk = ~clk;

  i2s_receiver dut (
    .clk         (clk),
    .resetn      (resetn),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_l     (frame_l),
    .frame_r     (frame_r),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
`ifdef I2S_RX_OVERRUN_CNT_EN
    .overrun_count (overrun_count),
`endif
    .locked      (locked)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every accepted frame must match the oldest expected pair.
  always @(negedge clk) begin
    if (resetn && overrun) ovr_pulses++;
    if (resetn && frame_valid && frame_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", {8'h0, frame_l}, 32'hFFFF_FFFF);
      end else begin
        logic [2*DB-1:0] e;
        e = sb.pop_front();
        check("frame_l", {8'h0, frame_l}, {8'h0, e[2*DB-1:DB]});
        check("frame_r", {8'h0, frame_r}, {8'h0, e[DB-1:0]});
      end
    end
  end

  // One bclk period = 8 clk; optional frame_ready pulse lands on the DUT's rise cycle.
  task automatic send_bit(input logic lr, input logic d, input logic pulse);
    bclk = 1'b0; lrclk = lr; sdata = d;
    repeat (4) begin @(posedge clk); #1; end
    bclk = 1'b1;
    if (pulse) begin
      repeat (2) begin @(posedge clk); #1; end
      frame_ready = 1'b1;
      @(posedge clk); #1;
      frame_ready = 1'b0;
      @(posedge clk); #1;
    end else begin
      repeat (4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_slot(input logic lr, input logic [DB-1:0] w, input int nbits, input logic pulse);
    for (int i = 0; i < nbits; i++)
      send_bit(lr, (i >= 1 && i <= DB) ? w[DB-i] : 1'b0, pulse && (i == DB));
  endtask

  task automatic send_pair(input logic [DB-1:0] l, input logic [DB-1:0] r, input logic expect_out);
    if (expect_out) sb.push_back({l, r});
    send_slot(1'b0, l, 32, 1'b0);
    send_slot(1'b1, r, 32, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    check(tag, sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'h0, frame_valid}, 0);
    check({tag, "_l"}, {8'h0, frame_l}, 0);
    check({tag, "_r"}, {8'h0, frame_r}, 0);
    check({tag, "_overrun"}, {31'h0, overrun}, 0);
    check({tag, "_locked"}, {31'h0, locked}, 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    check({tag, "_ocount"}, {16'h0, overrun_count}, 0);
`endif
  endtask

  initial begin
    resetn = 1'b0; bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0; frame_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_zero("reset");
    resetn = 1'b1;

    // Basic frames
    send_slot(1'b1, 24'h0, 32, 1'b0);
    check("idle_unlocked", {31'h0, locked}, 0);
    sb.push_back({24'hA5A5A5, 24'h5A5A5A});
    send_slot(1'b0, 24'hA5A5A5, 32, 1'b0);
    check("locked_left", {31'h0, locked}, 1);
    send_slot(1'b1, 24'h5A5A5A, 32, 1'b0);
    send_pair(24'h111111, 24'h222222, 1'b1);
    drain("basic_drain");

    // Startup in the middle of a right slot
    resetn = 1'b0; @(posedge clk); #1; resetn = 1'b1;
    send_slot(1'b1, 24'h0, 12, 1'b0);
    check("startup_unlocked", {31'h0, locked}, 0);
    send_pair(24'h123456, 24'h654321, 1'b1);
    drain("startup_drain");

    // Backpressure and overrun
    frame_ready = 1'b0;
    send_pair(24'h000001, 24'h000002, 1'b1);
    send_pair(24'h000003, 24'h000004, 1'b0);
    check("bp_valid", {31'h0, frame_valid}, 1);
    check("bp_l", {8'h0, frame_l}, 1);
    check("bp_r", {8'h0, frame_r}, 2);
    check("bp_overruns", ovr_pulses, 1);
`ifdef I2S_RX_OVERRUN_CNT_EN
    check("bp_ocount", {16'h0, overrun_count}, 1);
`endif
    frame_ready = 1'b1;
    drain("bp_drain");
    repeat (2) begin @(posedge clk); #1; end
    check("bp_valid_clear", {31'h0, frame_valid}, 0);

    // Accept in the exact cycle the next frame completes
    frame_ready = 1'b0;
    send_pair(24'hAAAAAA, 24'hBBBBBB, 1'b1);
    sb.push_back({24'hCCCCCC, 24'hDDDDDD});
    send_slot(1'b0, 24'hCCCCCC, 32, 1'b0);
    send_slot(1'b1, 24'hDDDDDD, 32, 1'b1);
    check("simul_valid", {31'h0, frame_valid}, 1);
    check("simul_l", {8'h0, frame_l}, 32'hCCCCCC);
    check("simul_r", {8'h0, frame_r}, 32'hDDDDDD);
    check("simul_no_overrun", ovr_pulses, 1);
    frame_ready = 1'b1;
    drain("simul_drain");

    // Short left slot forces resync
    send_slot(1'b0, 24'hFFFFFF, 10, 1'b0);
    send_slot(1'b1, 24'hFFFFFF, 32, 1'b0);
    check("short_unlocked", {31'h0, locked}, 0);
    check("short_no_frame", {31'h0, frame_valid}, 0);
    sb.push_back({24'h800000, 24'h7FFFFF});
    send_slot(1'b0, 24'h800000, 32, 1'b0);
    check("short_relock", {31'h0, locked}, 1);
    send_slot(1'b1, 24'h7FFFFF, 32, 1'b0);
    drain("short_drain");

    // Reset mid right word with a frame held
    frame_ready = 1'b0;
    send_pair(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    check("held_valid", {31'h0, frame_valid}, 1);
    send_slot(1'b0, 24'h135790, 32, 1'b0);
    send_slot(1'b1, 24'hFFFFFF, 12, 1'b0);
    resetn = 1'b0; @(posedge clk); #1; resetn = 1'b1;
    check_zero("midreset");
    frame_ready = 1'b1;
    send_slot(1'b1, 24'h0, 10, 1'b0);
    send_pair(24'h2468AC, 24'hFDB975, 1'b1);
    drain("midreset_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
